// File: rtl/i2c_burst_sequencer_if.sv
// i2c_burst_sequencer_if
// Groups the handshake between the burst sequencer and a byte-level I2C master.
//   i2c_busy     : master busy; each rising edge means a byte phase was latched
//   i2c_data_rd  : byte most recently read by the master
//   i2c_ena      : request the master to run (another) byte phase
//   i2c_addr     : 7-bit slave address
//   i2c_rw       : direction of the phase, 1 = read
//   i2c_data_wr  : byte to send in a write phase
//   i2c_ack_error: slave NACK indication (only with I2C_BURST_ACK_ERR_EN)
// modport master : the sequencer side (drives ena/addr/rw/data_wr)
// modport slave  : the byte-level I2C master side
interface i2c_burst_sequencer_if;
    logic       i2c_busy;
    logic [7:0] i2c_data_rd;
    logic       i2c_ena;
    logic [6:0] i2c_addr;
    logic       i2c_rw;
    logic [7:0] i2c_data_wr;
`ifdef I2C_BURST_ACK_ERR_EN
    logic       i2c_ack_error;

    modport master (input i2c_busy, i2c_data_rd, i2c_ack_error,
                    output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr);
    modport slave  (output i2c_busy, i2c_data_rd, i2c_ack_error,
                    input i2c_ena, i2c_addr, i2c_rw, i2c_data_wr);
`else
    modport master (input i2c_busy, i2c_data_rd,
                    output i2c_ena, i2c_addr, i2c_rw, i2c_data_wr);
    modport slave  (output i2c_busy, i2c_data_rd,
                    input i2c_ena, i2c_addr, i2c_rw, i2c_data_wr);
`endif
endinterface

// File: rtl/i2c_burst_sequencer.sv
// i2c_burst_sequencer
// Runs one complete I2C register transaction (write or read burst) per request
// on top of a byte-level I2C master using the busy/ena/rw handshake.
// Byte phases are counted on rising edges of i2c_busy: the register address
// (REG_ADDR_BYTES, MSB first) followed by L data bytes.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   chip_addr     : 7-bit slave address
//   reg_addr      : register address, REG_ADDR_BYTES bytes
//   wdata         : write data, byte 0 in [7:0] sent first
//   len           : requested byte count (0 = pointer write / 1-byte read,
//                   values above MAX_BYTES clamp)
//   is_read       : 1 = read burst
//   enable        : request strobe, sampled only while idle
//   rdata         : read data, byte r at [8r+7:8r]
//   done          : level, high while idle
//   error         : NACK seen in the last transaction (I2C_BURST_ACK_ERR_EN)
//   i2c           : handshake to the byte-level master
// Optional feature macro: I2C_BURST_ACK_ERR_EN (adds NACK observation).
module i2c_burst_sequencer #(
    parameter int REG_ADDR_BYTES = 1,
    parameter int MAX_BYTES      = 4,
    parameter int LEN_W          = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  chip_addr,
    input  logic [8*REG_ADDR_BYTES-1:0] reg_addr,
    input  logic [8*MAX_BYTES-1:0]      wdata,
    input  logic [LEN_W-1:0]            len,
    input  logic                        is_read,
    input  logic                        enable,
    output logic [8*MAX_BYTES-1:0]      rdata,
    output logic                        done,
`ifdef I2C_BURST_ACK_ERR_EN
    output logic                        error,
`endif
    i2c_burst_sequencer_if.master       i2c
);
    localparam int CNT_W = $clog2(REG_ADDR_BYTES + MAX_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                busy_prev_q;
    logic                                done_q, done_d;
    logic                                ena_q, ena_d;
    logic                                rw_q, rw_d;
    logic [6:0]                          addr_q, addr_d;
    logic [7:0]                          data_wr_q, data_wr_d;
    logic [MAX_BYTES-1:0][7:0]           rdata_q, rdata_d;
    logic [REG_ADDR_BYTES-1:0][7:0]      reg_q, reg_d;
    logic [MAX_BYTES-1:0][7:0]           wdata_q, wdata_d;
    logic [LEN_W-1:0]                    len_q, len_d;
    logic                                rd_q, rd_d;
    logic                                err_q, err_d;

    logic [LEN_W-1:0] len_eff;
    logic [CNT_W-1:0] total;
    logic             busy_rise;
    logic             nack;

`ifdef I2C_BURST_ACK_ERR_EN
    assign nack  = i2c.i2c_ack_error;
    assign error = err_q;
`else
    // Without the feature err_q is a constant 0 and gets pruned.
    assign nack  = 1'b0;
`endif

    // Effective length: clamp, and a zero-length read still reads one byte.
    always_comb begin
        len_eff = len;
        if (len > LEN_W'(MAX_BYTES)) begin
            len_eff = LEN_W'(MAX_BYTES);
        end else if (len == '0 && is_read) begin
            len_eff = LEN_W'(1);
        end
    end

    assign total     = CNT_W'(REG_ADDR_BYTES) + CNT_W'(len_q);
    assign busy_rise = i2c.i2c_busy & ~busy_prev_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        ena_d     = ena_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        data_wr_d = data_wr_q;
        rdata_d   = rdata_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        rd_d      = rd_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    addr_d  = chip_addr;
                    reg_d   = reg_addr;
                    wdata_d = wdata;
                    len_d   = len_eff;
                    rd_d    = is_read;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    ena_d   = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                ena_d = 1'b1;
                if (busy_rise) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (nack) begin
                    ena_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = WAIT;
                end else if (busy_rise) begin
                    // The byte of read phase r is valid once the master has
                    // moved on and latched the following phase.
                    if (rd_q) begin
                        for (int r = 0; r < MAX_BYTES; r++) begin
                            if (cnt_d == CNT_W'(REG_ADDR_BYTES + r + 2) && cnt_d <= total) begin
                                rdata_d[r] = i2c.i2c_data_rd;
                            end
                        end
                    end
                    // Last phase latched: drop ena so the master stops after it.
                    if (cnt_d == total) begin
                        ena_d   = 1'b0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                ena_d = 1'b0;
                if (!i2c.i2c_busy) begin
                    // Final read byte has no following phase; take it here.
                    if (rd_q && !err_q) begin
                        for (int r = 0; r < MAX_BYTES; r++) begin
                            if (len_q == LEN_W'(r + 1)) begin
                                rdata_d[r] = i2c.i2c_data_rd;
                            end
                        end
                    end
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                ena_d   = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Present the byte for the phase the master will latch next.
        if (state_d == XFER) begin
            if (cnt_d < CNT_W'(REG_ADDR_BYTES)) begin
                rw_d = 1'b0;
                for (int i = 0; i < REG_ADDR_BYTES; i++) begin
                    if (cnt_d == CNT_W'(REG_ADDR_BYTES - 1 - i)) begin
                        data_wr_d = reg_d[i];
                    end
                end
            end else if (!rd_d) begin
                rw_d = 1'b0;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (cnt_d == CNT_W'(REG_ADDR_BYTES + i)) begin
                        data_wr_d = wdata_d[i];
                    end
                end
            end else begin
                rw_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_prev_q <= 1'b0;
            done_q      <= 1'b1;
            ena_q       <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_wr_q   <= '0;
            rdata_q     <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_prev_q <= i2c.i2c_busy;
            done_q      <= done_d;
            ena_q       <= ena_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_wr_q   <= data_wr_d;
            rdata_q     <= rdata_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
        end
    end

    assign done            = done_q;
    assign rdata           = rdata_q;
    assign i2c.i2c_ena     = ena_q;
    assign i2c.i2c_addr    = addr_q;
    assign i2c.i2c_rw      = rw_q;
    assign i2c.i2c_data_wr = data_wr_q;
endmodule

// File: tb/tb_i2c_burst_sequencer.sv
// Bench for i2c_burst_sequencer with a 2-byte register address: a byte-level
// I2C master model drives busy/data_rd and logs every latched phase, and a
// reference model derives the expected phase list and rdata per request.
module tb_i2c_burst_sequencer;
    localparam int RA = 2;
    localparam int MB = 4;
    localparam int LW = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  chip_addr = '0;
    logic [15:0] reg_addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  len = '0;
    logic        is_read = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] rdata;
    logic        done;
`ifdef I2C_BURST_ACK_ERR_EN
    logic        error;
`endif

    always #5 clk = ~clk;

    i2c_burst_sequencer_if bus();

    i2c_burst_sequencer #(.REG_ADDR_BYTES(RA), .MAX_BYTES(MB), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .chip_addr(chip_addr), .reg_addr(reg_addr),
        .wdata(wdata), .len(len), .is_read(is_read), .enable(enable),
        .rdata(rdata), .done(done),
`ifdef I2C_BURST_ACK_ERR_EN
        .error(error),
`endif
        .i2c(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- byte-level master model ----------------
    logic [7:0]  slave_mem [MB];
    logic [15:0] log_ph[$];   // {addr, rw, data_wr} per latched phase
    logic [8:0]  exp_ph[$];   // {rw, data_wr} expected per phase
    int rd_idx = 0;
    int rise_cnt = 0;
    int exp_t_cur = 0;

    initial begin
        logic cur_rw;
        int   hold;
        bus.i2c_busy = 1'b0;
        bus.i2c_data_rd = 8'h00;
`ifdef I2C_BURST_ACK_ERR_EN
        bus.i2c_ack_error = 1'b0;
`endif
        forever begin
            @(posedge clk); #1;
            if (reset && bus.i2c_ena && !bus.i2c_busy) begin
                bus.i2c_busy = 1'b1;
                rise_cnt++;
                cur_rw = bus.i2c_rw;
                log_ph.push_back({bus.i2c_addr, bus.i2c_rw, bus.i2c_data_wr});
                hold = $urandom_range(2, 5);
                @(posedge clk); #1;
                // ena must drop right after the last phase is latched
                chk("ena_after_rise", bus.i2c_ena, (rise_cnt == exp_t_cur) ? 1'b0 : 1'b1);
                repeat (hold - 1) @(posedge clk);
                #1 bus.i2c_busy = 1'b0;
                if (cur_rw) begin
                    bus.i2c_data_rd = (rd_idx < MB) ? slave_mem[rd_idx] : 8'hEE;
                    rd_idx++;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model(input logic [15:0] rg, input logic [31:0] wd, input logic [2:0] ln,
                         input logic rd, input logic [31:0] sl,
                         output int t, output logic [31:0] erd);
        int L;
        L = int'(ln);
        if (L > MB) L = MB;
        if (L == 0 && rd) L = 1;
        exp_ph.delete();
        for (int i = 0; i < RA; i++) exp_ph.push_back({1'b0, 8'(rg >> (8 * (RA - 1 - i)))});
        for (int i = 0; i < L; i++) begin
            if (rd) exp_ph.push_back({1'b1, rg[7:0]});
            else    exp_ph.push_back({1'b0, 8'(wd >> (8 * i))});
        end
        erd = '0;
        if (rd) for (int i = 0; i < L; i++) erd[8*i +: 8] = sl[8*i +: 8];
        t = RA + L;
    endtask

    task automatic start_req(input logic [6:0] ch, input logic [15:0] rg, input logic [31:0] wd,
                             input logic [2:0] ln, input logic rd, input logic [31:0] sl);
        int t;
        logic [31:0] erd;
        model(rg, wd, ln, rd, sl, t, erd);
        for (int i = 0; i < MB; i++) slave_mem[i] = sl[8*i +: 8];
        log_ph.delete();
        rise_cnt = 0;
        rd_idx = 0;
        exp_t_cur = t;
        @(posedge clk); #1;
        chip_addr = ch; reg_addr = rg; wdata = wd; len = ln; is_read = rd; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk("ena_latency", bus.i2c_ena, 1'b1);
        chk("done_low", done, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", done, 1'b1);
    endtask

    task automatic run_txn(input logic [6:0] ch, input logic [15:0] rg, input logic [31:0] wd,
                           input logic [2:0] ln, input logic rd, input logic [31:0] sl);
        int t;
        logic [31:0] erd;
        model(rg, wd, ln, rd, sl, t, erd);
        start_req(ch, rg, wd, ln, rd, sl);
        wait_done();
        chk("phase_count", log_ph.size(), t);
        for (int i = 0; i < t && i < log_ph.size(); i++)
            chk("phase", log_ph[i], {ch, exp_ph[i]});
        chk("rdata", rdata, erd);
    endtask

    typedef struct {
        logic [6:0]  chip;
        logic [15:0] rg;
        logic [31:0] wd;
        logic [2:0]  ln;
        logic        rd;
        logic [31:0] sl;
        int          exp_t;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{7'h3D, 16'h0012, 32'h000000A5, 3'd1, 1'b0, 32'h0,        3, 32'h0};
        vt[1] = '{7'h50, 16'h1234, 32'h00CCBBAA, 3'd3, 1'b0, 32'h0,        5, 32'h0};
        vt[2] = '{7'h21, 16'h0040, 32'h0,        3'd2, 1'b1, 32'h44332211, 4, 32'h00002211};
        vt[3] = '{7'h11, 16'hABCD, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h0,        2, 32'h0};
        vt[4] = '{7'h12, 16'h0102, 32'h44332211, 3'd7, 1'b0, 32'h0,        6, 32'h0};
        vt[5] = '{7'h13, 16'h0203, 32'h0,        3'd0, 1'b1, 32'h9988775A, 3, 32'h0000005A};
        vt[6] = '{7'h14, 16'h0304, 32'h0,        3'd4, 1'b1, 32'h04030201, 6, 32'h04030201};
        vt[7] = '{7'h15, 16'h0405, 32'h0,        3'd5, 1'b1, 32'hDEADBEEF, 6, 32'hDEADBEEF};

        // reset values, checked while still in reset
        #12;
        chk("rst_done", done, 1'b1);
        chk("rst_ena", bus.i2c_ena, 1'b0);
        chk("rst_rw", bus.i2c_rw, 1'b0);
        chk("rst_addr", bus.i2c_addr, 7'h0);
        chk("rst_data_wr", bus.i2c_data_wr, 8'h0);
        chk("rst_rdata", rdata, 32'h0);
        #20 reset = 1'b1;

        // table-driven directed vectors
        for (int v = 0; v < 8; v++) begin
            run_txn(vt[v].chip, vt[v].rg, vt[v].wd, vt[v].ln, vt[v].rd, vt[v].sl);
            chk("vec_phases", log_ph.size(), vt[v].exp_t);
            chk("vec_rdata", rdata, vt[v].exp_rdata);
        end

        // enable pulsed during XFER with different request: must be ignored
        fork
            run_txn(7'h2A, 16'h5566, 32'h00332211, 3'd3, 1'b0, 32'h0);
            begin
                repeat (5) @(posedge clk);
                #1 chip_addr = 7'h7F; reg_addr = 16'hFFFF; wdata = 32'hFFFFFFFF;
                is_read = 1'b1; enable = 1'b1;
                @(posedge clk); #1 enable = 1'b0;
            end
        join

        // reset in the middle of a read burst
        begin
            int n = 0;
            start_req(7'h33, 16'h0102, 32'h0, 3'd4, 1'b1, 32'hDDCCBBAA);
            while (rise_cnt < 4 && n < 300) begin @(posedge clk); #1; n++; end
            chk("midrst_rise_timeout", rise_cnt >= 4, 1'b1);
            @(posedge clk); #2;
            chk("midrst_partial_rdata", rdata, 32'h000000AA);
            chk("midrst_busy_done", done, 1'b0);
            reset = 1'b0;
            #1;
            chk("midrst_ena", bus.i2c_ena, 1'b0);
            chk("midrst_done", done, 1'b1);
            chk("midrst_rdata", rdata, 32'h0);
            repeat (20) @(posedge clk);
            #3 reset = 1'b1;
            run_txn(7'h34, 16'h0A0B, 32'h00000077, 3'd1, 1'b0, 32'h0);
        end

`ifdef I2C_BURST_ACK_ERR_EN
        // NACK on a register byte of a read
        begin
            int n = 0;
            start_req(7'h44, 16'h0020, 32'h0, 3'd2, 1'b1, 32'h00006655);
            while (rise_cnt < 1 && n < 300) begin @(posedge clk); #1; n++; end
            @(posedge clk); #2 bus.i2c_ack_error = 1'b1;
            @(posedge clk); #1 bus.i2c_ack_error = 1'b0;
            chk("nack_ena", bus.i2c_ena, 1'b0);
            chk("nack_error", error, 1'b1);
            wait_done();
            chk("nack_rdata", rdata, 32'h0);
            run_txn(7'h45, 16'h0021, 32'h0, 3'd1, 1'b1, 32'h000000C3);
            chk("nack_cleared", error, 1'b0);
        end
`endif

        // randomized requests against the reference model
        for (int k = 0; k < 20; k++) begin
            run_txn(7'($urandom), 16'($urandom), $urandom, 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
